gate_truth_checker: RTL and testbench
=====================================

# gate_truth_checker

Self-checking truth-table sequencer for any 2-input combinational gate in the lab library. It drives the gate's `a`/`b` inputs through all four combinations, waits a settle interval, samples `y`, and compares it against an expected 4-bit truth table. It sits opposite the gate under test: it generates stimulus and consumes the response in synthesizable logic, so gate checks can run in hardware as well as in simulation.

## Interface
- `SETTLE_CYCLES`, default 2: cycles each vector is held before `y` is sampled. Legal range is 1 or more; 0 is illegal.
- `EXP_TT`, default 4'b0001 (NOR): expected `y` per vector. The bit index is `{a,b}`.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request to run a check; honoured only in IDLE.
- `y`  in  1  output of the gate under test.
- `a`  out  1  registered stimulus to the gate under test.
- `b`  out  1  registered stimulus to the gate under test.
- `busy`  out  1  high in SETTLE and SAMPLE.
- `done`  out  1  one-cycle pulse when the run completes.
- `pass`  out  1  high when the last run had zero mismatches; held until the next start.
- `err_count`  out  3  mismatch count for the last run, 0..4.
- `fail_vec`  out  4  bit i set when vector i (`{a,b}`=i) mismatched.
- `obs_tt`  out  4  observed truth table (see Configuration).

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE with `start`=1 → SETTLE:
  - idx=0 and `{a,b}`=00.
  - settle count=0.
  - `err_count`, `fail_vec`, `pass` and `obs_tt` cleared.
- SETTLE:
  - The count increments each cycle.
  - When the count reaches SETTLE_CYCLES-1, the state moves to SAMPLE. SETTLE therefore lasts exactly SETTLE_CYCLES cycles.
- SAMPLE (one cycle):
  - On the edge leaving SAMPLE, compare `y` with `EXP_TT[idx]`.
  - On mismatch: set `fail_vec[idx]` and increment `err_count` (saturating is not needed; the maximum is 4).
- After SAMPLE:
  - If idx<3: idx+1, `{a,b}`=idx+1, count=0, go to SETTLE.
  - If idx==3: go to DONE. `pass` takes the value (next `fail_vec`==0).
- DONE (one cycle): `done`=1, then unconditionally return to IDLE. `start` is ignored in DONE.
- `start` is ignored in SETTLE, SAMPLE and DONE. No queuing.
- `a`/`b` hold 11 after a run until the next start or reset.
- `y` is treated as a plain input. The settle interval covers gate propagation; no synchronizer is used.

## Timing
- Reset values (applied immediately, asynchronously):
  - state=IDLE.
  - `a`=`b`=0, `busy`=0, `done`=0, `pass`=0.
  - `err_count`=0, `fail_vec`=0, `obs_tt`=0.
- Reset mid-run aborts with no `done` pulse and discards partial results.
- `start` sampled at edge E puts SETTLE for vector 0 in effect at E+1.
- Each vector takes SETTLE_CYCLES+1 cycles.
- `done`=1 in the cycle beginning at edge E+4·(SETTLE_CYCLES+1)+1. With the default, that is E+13.
- `pass`, `err_count` and `fail_vec` are final and valid in the `done` cycle and afterwards.
- `busy` is high from E+1 through the last SAMPLE cycle, and low in DONE.

## Configuration
- Macro `GATE_CHK_CAPTURE_EN`.
- Defined: `obs_tt[idx]` is loaded with `y` in each SAMPLE and is valid from the `done` cycle. This lets the bench identify which gate is actually connected.
- Undefined: `obs_tt` is tied to 4'b0000 and no capture register is built. All other behaviour is identical.

## Structure
- Package `gate_chk_pkg` holds:
  - the state enum.
  - truth-table constants `TT_AND`=4'b1000, `TT_OR`=4'b1110, `TT_NAND`=4'b0111, `TT_NOR`=4'b0001, `TT_XOR`=4'b0110, `TT_XNOR`=4'b1001.
- One sub-module, `gate_chk_settle_ctr`:
  - `$clog2(SETTLE_CYCLES+1)`-bit counter.
  - clear input and `expired` output.
  - instantiated once.
- The top level holds the FSM, idx, stimulus and result registers.

## Test plan
All scenarios use SETTLE_CYCLES=2.
- Reset: assert `rst` at any point → all outputs immediately at reset values. `a`=`b`=0.
- Correct NOR gate with `EXP_TT`=`TT_NOR`, `start` pulse at edge E:
  - `{a,b}` steps 00,01,10,11, each held 3 cycles.
  - `done` pulses in the cycle after edge E+13.
  - `pass`=1, `err_count`=0, `fail_vec`=0000.
- `y` tied 0 with `TT_NOR` → `fail_vec`=0001, `err_count`=1, `pass`=0.
- OR gate connected with `TT_NOR`:
  - `fail_vec`=1111, `err_count`=4, `pass`=0.
  - With `GATE_CHK_CAPTURE_EN`, `obs_tt`=1110.
- `start` held high throughout:
  - The run is not restarted while busy or in DONE.
  - A new run begins on the edge after returning to IDLE, and the previous results are cleared at that edge.
- Reset pulse during SETTLE of vector 2:
  - Outputs reset immediately, with no `done` pulse.
  - A subsequent `start` performs a full clean run with `pass`=1.

Source files
------------

// File: rtl/gate_chk_pkg.sv
// Shared types and constants for the 2-input gate truth-table checker.
// Used by gate_truth_checker (optional capture via GATE_CHK_CAPTURE_EN) and
// gate_chk_settle_ctr.
package gate_chk_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSettle = 2'd1,
    StSample = 2'd2,
    StDone   = 2'd3
  } gate_chk_state_e;

  // Truth tables indexed by {a,b}.
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_XNOR = 4'b1001;

endpackage

// File: rtl/gate_chk_settle_ctr.sv
// Settle-interval counter: counts up from zero while clear is low and flags
// the last settle cycle. SETTLE_CYCLES must be 1 or more.
module gate_chk_settle_ctr
  import gate_chk_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic expired
);

  localparam int unsigned CntW = $clog2(SETTLE_CYCLES + 1);

  logic [CntW-1:0] cnt_q;

  // Count register; held at zero whenever clear is asserted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  assign expired = (cnt_q == CntW'(SETTLE_CYCLES - 1));

endmodule

// File: rtl/gate_truth_checker.sv
// Truth-table sequencer for a 2-input gate: steps {a,b} through 00..11, holds
// each vector SETTLE_CYCLES cycles, samples y, and scores it against EXP_TT.
// Define GATE_CHK_CAPTURE_EN to build the observed truth-table register
// (obs_tt); otherwise obs_tt is tied to zero.
module gate_truth_checker
  import gate_chk_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [3:0]  EXP_TT        = TT_NOR
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       y,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_vec,
  output logic [3:0] obs_tt
);

  gate_chk_state_e state_q, state_d;

  // arm_q marks the cycle after start was accepted: results are cleared on the
  // accepting edge, and the run itself enters SETTLE one edge later.
  logic       arm_q, arm_d;
  logic [1:0] idx_q, idx_d;
  logic [2:0] err_q, err_d;
  logic [3:0] fail_q, fail_d;
  logic       pass_q, pass_d;
  logic       settle_done;
  logic       mismatch;

`ifdef GATE_CHK_CAPTURE_EN
  logic [3:0] obs_q, obs_d;
`endif

  gate_chk_settle_ctr #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle_ctr (
    .clk    (clk),
    .rst    (rst),
    .clear  (state_q != StSettle),
    .expired(settle_done)
  );

  assign mismatch = (y != EXP_TT[idx_q]);

  // Next-state, stimulus index and result scoring.
  always_comb begin
    state_d = state_q;
    arm_d   = 1'b0;
    idx_d   = idx_q;
    err_d   = err_q;
    fail_d  = fail_q;
    pass_d  = pass_q;
`ifdef GATE_CHK_CAPTURE_EN
    obs_d   = obs_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (arm_q) begin
          state_d = StSettle;
          idx_d   = 2'd0;
        end else if (start) begin
          arm_d  = 1'b1;
          err_d  = 3'd0;
          fail_d = 4'd0;
          pass_d = 1'b0;
`ifdef GATE_CHK_CAPTURE_EN
          obs_d  = 4'd0;
`endif
        end
      end
      StSettle: begin
        if (settle_done) begin
          state_d = StSample;
        end
      end
      StSample: begin
        if (mismatch) begin
          fail_d[idx_q] = 1'b1;
          err_d         = err_q + 3'd1;
        end
`ifdef GATE_CHK_CAPTURE_EN
        obs_d[idx_q] = y;
`endif
        if (idx_q == 2'd3) begin
          state_d = StDone;
          pass_d  = (fail_d == 4'd0);
        end else begin
          idx_d   = idx_q + 2'd1;
          state_d = StSettle;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State, stimulus and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      arm_q   <= 1'b0;
      idx_q   <= 2'd0;
      err_q   <= 3'd0;
      fail_q  <= 4'd0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      arm_q   <= arm_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
      pass_q  <= pass_d;
    end
  end

`ifdef GATE_CHK_CAPTURE_EN
  // Observed truth-table capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      obs_q <= 4'd0;
    end else begin
      obs_q <= obs_d;
    end
  end
  assign obs_tt = obs_q;
`else
  assign obs_tt = 4'b0000;
`endif

  // Stimulus is the registered vector index itself, so {a,b} rests at 11.
  assign a         = idx_q[1];
  assign b         = idx_q[0];
  assign busy      = (state_q == StSettle) || (state_q == StSample);
  assign done      = (state_q == StDone);
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_vec  = fail_q;

endmodule

// File: tb/tb_gate_truth_checker.sv
// Bench for gate_truth_checker: a modelled gate under test drives y from its
// own truth table; expected results come from comparing tables directly.
// Honours GATE_CHK_CAPTURE_EN for the obs_tt expectation.
module tb_gate_truth_checker;
  import gate_chk_pkg::*;

  localparam int unsigned SettleCycles = 2;
  localparam int          VecCycles    = SettleCycles + 1;
  localparam int          DoneOfs      = 4 * VecCycles + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       y;
  logic       a;
  logic       b;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] err_count;
  logic [3:0] fail_vec;
  logic [3:0] obs_tt;

  logic [3:0] gut_tt;
  assign y = gut_tt[{a, b}];

  int n_tests = 0;
  int n_fail  = 0;

  gate_truth_checker #(
    .SETTLE_CYCLES(SettleCycles),
    .EXP_TT       (TT_NOR)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .y        (y),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .err_count(err_count),
    .fail_vec (fail_vec),
    .obs_tt   (obs_tt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] exp_obs(input logic [3:0] tt);
`ifdef GATE_CHK_CAPTURE_EN
    return tt;
`else
    return 4'b0000;
`endif
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_ab"},   32'({a, b}),  32'd0);
    check({tag, "_busy"}, 32'(busy),    32'd0);
    check({tag, "_done"}, 32'(done),    32'd0);
    check({tag, "_pass"}, 32'(pass),    32'd0);
    check({tag, "_err"},  32'(err_count), 32'd0);
    check({tag, "_fail"}, 32'(fail_vec),  32'd0);
    check({tag, "_obs"},  32'(obs_tt),    32'd0);
  endtask

  // Full run against gate table tt, with a one-cycle start pulse.
  task automatic run_check(input string tag, input logic [3:0] tt);
    logic [3:0] ef;
    ef     = tt ^ TT_NOR;
    gut_tt = tt;
    start  = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_clr_err"},  32'(err_count), 32'd0);
    check({tag, "_clr_pass"}, 32'(pass),      32'd0);
    for (int k = 1; k <= DoneOfs; k++) begin
      tick();
      if (k < DoneOfs) begin
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_ab"},   32'({a, b}), 32'((k - 1) / VecCycles));
        check({tag, "_done0"}, 32'(done), 32'd0);
      end else begin
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_busyd"}, 32'(busy), 32'd0);
        check({tag, "_pass"}, 32'(pass), 32'(ef == 4'd0));
        check({tag, "_err"},  32'(err_count), 32'($countones(ef)));
        check({tag, "_fail"}, 32'(fail_vec), 32'(ef));
        check({tag, "_obs"},  32'(obs_tt), 32'(exp_obs(tt)));
      end
    end
    tick();
    check({tag, "_pulse"}, 32'(done), 32'd0);
    check({tag, "_ab11"},  32'({a, b}), 32'd3);
  endtask

  initial begin
    int done_seen;
    rst    = 1'b1;
    start  = 1'b0;
    gut_tt = TT_NOR;
    #2;
    check_reset_vals("rst");
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check_reset_vals("idle");

    run_check("nor", TT_NOR);
    run_check("tie0", 4'b0000);
    run_check("or", TT_OR);
    for (int i = 0; i < 8; i++) begin
      run_check("rnd", 4'($urandom_range(0, 15)));
    end

    // Reset during SETTLE of vector 2 after a mismatch has been scored.
    gut_tt = 4'b0000;
    start  = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 2 * VecCycles + 1; k++) tick();
    check("mid_ab",  32'({a, b}), 32'd2);
    check("mid_err", 32'(err_count), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_vals("midrst");
    tick();
    rst = 1'b0;
    done_seen = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (done) done_seen++;
    end
    check("midrst_nodone", 32'(done_seen), 32'd0);
    run_check("after_rst", TT_NOR);

    // start held high: no restart until back in IDLE, then a fresh run.
    gut_tt = TT_NOR;
    start  = 1'b1;
    tick();
    for (int k = 1; k <= 2 * DoneOfs + 2; k++) begin
      tick();
      if (k < DoneOfs) check("hold_busy", 32'(busy), 32'd1);
      if (k == DoneOfs) check("hold_pass1", 32'(pass), 32'd1);
      if (k == DoneOfs + 1) begin
        check("hold_idle", 32'(busy), 32'd0);
        check("hold_keep", 32'(pass), 32'd1);
        gut_tt = TT_OR;
      end
      if (k == DoneOfs + 2) begin
        check("hold_clr", 32'(pass), 32'd0);
        check("hold_arm", 32'(busy), 32'd0);
      end
      if (k == DoneOfs + 3) check("hold_restart", 32'(busy), 32'd1);
      check("hold_done", 32'(done), 32'((k == DoneOfs) || (k == 2 * DoneOfs + 2)));
      if (k == 2 * DoneOfs + 2) begin
        check("hold_err2",  32'(err_count), 32'd4);
        check("hold_fail2", 32'(fail_vec), 32'hf);
        check("hold_obs2",  32'(obs_tt), 32'(exp_obs(TT_OR)));
      end
    end
    start = 1'b0;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
